// File: rtl/intr_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// intr_pkg : shared encodings for interrupt_controller (states, codes, priority)
// Rev 1.0
// ----------------------------------------------------------------------------
package intr_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] code_t;

  localparam logic [1:0] ST_KERNEL  = 2'd0;
  localparam logic [1:0] ST_USER    = 2'd1;
  localparam logic [1:0] ST_REQ     = 2'd2;
  localparam logic [1:0] ST_SERVICE = 2'd3;

  localparam logic [1:0] INT_NONE  = 2'd0;
  localparam logic [1:0] INT_TIMER = 2'd1;
  localparam logic [1:0] INT_IO    = 2'd2;
  localparam logic [1:0] INT_DISK  = 2'd3;

  // Fixed service order: io first, then disk, then the quantum timer.
  function automatic code_t prio_encode(input logic io, input logic disk, input logic tmr);
    code_t res;
    if (io)        res = INT_IO;
    else if (disk) res = INT_DISK;
    else if (tmr)  res = INT_TIMER;
    else           res = INT_NONE;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_pend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// edge_pend : rising-edge detector feeding a sticky pending bit with clear
// Rev 1.0
// ----------------------------------------------------------------------------
module edge_pend (
  input  logic clk,
  input  logic rst,
  input  logic lvl_i,
  input  logic clr_i,
  output logic pend_o
);

  logic dly_q;
  logic pend_q;
  logic pend_d;
  logic rise;

  assign rise = lvl_i & ~dly_q;
  // A fresh edge wins over a same-cycle clear so it is serviced next time.
  assign pend_d = rise | (pend_q & ~clr_i);
  assign pend_o = pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      dly_q  <= lvl_i;
      pend_q <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// interrupt_controller : latches io/disk/timer sources, raises intr in user mode
// Rev 1.0
// ----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int QUANTUM = 1000,
  parameter int CNT_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              userMode,
  input  logic              kernelMode,
  input  logic              inta,
  input  logic              clearIntr,
  input  logic              ioReq,
  input  logic              diskDone,
  input  logic [DATA_W-1:0] pc,
  output logic              intr,
  output logic [DATA_W-1:0] intCode,
  output logic [DATA_W-1:0] intPc,
  output logic              userRun
);

  import intr_pkg::*;

  state_t            state_q, state_d;
  code_t             code_q, code_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              intr_q;

  logic  io_pend, dk_pend, tmr_pend;
  logic  take;
  code_t take_code;
  logic  clr_io, clr_dk, clr_tmr;
  logic  enter_user;

  edge_pend u_io_pend (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  (ioReq),
    .clr_i  (clr_io),
    .pend_o (io_pend)
  );

  edge_pend u_dk_pend (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  (diskDone),
    .clr_i  (clr_dk),
    .pend_o (dk_pend)
  );

  assign take_code  = prio_encode(io_pend, dk_pend, tmr_pend);
  assign clr_io     = take && (take_code == INT_IO);
  assign clr_dk     = take && (take_code == INT_DISK);
  assign clr_tmr    = take && (take_code == INT_TIMER);
  assign enter_user = (state_d == ST_USER) && (state_q != ST_USER);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pc_d    = pc_q;
    take    = 1'b0;
    case (state_q)
      ST_KERNEL: begin
        if (userMode) state_d = ST_USER;
      end
      ST_USER: begin
        // A syscall takes precedence; any pending source waits for the next user run.
        if (kernelMode) begin
          state_d = ST_KERNEL;
        end else if (io_pend || dk_pend || tmr_pend) begin
          state_d = ST_REQ;
          take    = 1'b1;
          code_d  = take_code;
          pc_d    = pc;
        end
      end
      ST_REQ: begin
        if (inta) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (userMode) begin
          state_d = ST_USER;
          code_d  = INT_NONE;
        end else if (clearIntr) begin
          state_d = ST_KERNEL;
          code_d  = INT_NONE;
        end
      end
      default: state_d = ST_KERNEL;
    endcase
  end

  generate
    if (QUANTUM > 0) begin : g_timer
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tpend_q, tpend_d;
      logic             tick;

      // The expiring cycle itself counts as pending so a slice is exactly QUANTUM cycles.
      assign tick     = (state_q == ST_USER) && (cnt_q == CNT_LAST);
      assign tmr_pend = tpend_q | tick;
      assign tpend_d  = tmr_pend & ~clr_tmr;

      always_comb begin
        cnt_d = cnt_q;
        if (enter_user)              cnt_d = '0;
        else if (state_q == ST_USER) cnt_d = tick ? '0 : cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q   <= '0;
          tpend_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          tpend_q <= tpend_d;
        end
      end
    end else begin : g_no_timer
      assign tmr_pend = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_KERNEL;
      code_q  <= INT_NONE;
      pc_q    <= '0;
      intr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      intr_q  <= (state_d == ST_REQ);
    end
  end

  assign intr    = intr_q;
  assign intCode = {{(DATA_W-2){1'b0}}, code_q};
  assign intPc   = pc_q;
  assign userRun = (state_q == ST_USER);

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_interrupt_controller : directed scenarios plus random traffic vs a reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int QUANTUM = 8;
  localparam int CNT_W   = 16;
  localparam int DATA_W  = 32;

  localparam int S_KERNEL  = 0;
  localparam int S_USER    = 1;
  localparam int S_REQ     = 2;
  localparam int S_SERVICE = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              userMode = 1'b0;
  logic              kernelMode = 1'b0;
  logic              inta = 1'b0;
  logic              clearIntr = 1'b0;
  logic              ioReq = 1'b0;
  logic              diskDone = 1'b0;
  logic [DATA_W-1:0] pc = '0;
  logic              intr;
  logic [DATA_W-1:0] intCode;
  logic [DATA_W-1:0] intPc;
  logic              userRun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_state;
  bit          m_io_p, m_dk_p, m_tm_p;
  bit          m_io_prev, m_dk_prev;
  int          m_cnt;
  logic [31:0] m_code;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  interrupt_controller #(
    .QUANTUM (QUANTUM),
    .CNT_W   (CNT_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .userMode   (userMode),
    .kernelMode (kernelMode),
    .inta       (inta),
    .clearIntr  (clearIntr),
    .ioReq      (ioReq),
    .diskDone   (diskDone),
    .pc         (pc),
    .intr       (intr),
    .intCode    (intCode),
    .intPc      (intPc),
    .userRun    (userRun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_KERNEL;
    m_io_p = 0; m_dk_p = 0; m_tm_p = 0;
    m_io_prev = 0; m_dk_prev = 0;
    m_cnt = 0; m_code = 0; m_pc = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present before the edge.
  task automatic model_edge();
    bit io_r, dk_r, tick, tm_av, tk_io, tk_dk, tk_tm;
    int ns;
    io_r  = ioReq && !m_io_prev;
    dk_r  = diskDone && !m_dk_prev;
    tick  = (m_state == S_USER) && (m_cnt == QUANTUM - 1);
    tm_av = m_tm_p || tick;
    tk_io = 0; tk_dk = 0; tk_tm = 0;
    ns = m_state;
    case (m_state)
      S_KERNEL: if (userMode) begin ns = S_USER; m_cnt = 0; end
      S_USER: begin
        m_cnt = tick ? 0 : m_cnt + 1;
        if (kernelMode) ns = S_KERNEL;
        else if (m_io_p || m_dk_p || tm_av) begin
          ns = S_REQ;
          m_pc = pc;
          if (m_io_p)      begin m_code = 2; tk_io = 1; end
          else if (m_dk_p) begin m_code = 3; tk_dk = 1; end
          else             begin m_code = 1; tk_tm = 1; end
        end
      end
      S_REQ: if (inta) ns = S_SERVICE;
      default: begin
        if (userMode)       begin ns = S_USER; m_code = 0; m_cnt = 0; end
        else if (clearIntr) begin ns = S_KERNEL; m_code = 0; end
      end
    endcase
    m_io_p    = io_r || (m_io_p && !tk_io);
    m_dk_p    = dk_r || (m_dk_p && !tk_dk);
    m_tm_p    = tm_av && !tk_tm;
    m_io_prev = ioReq;
    m_dk_prev = diskDone;
    m_state   = ns;
  endtask

  task automatic check_all();
    check("intr",    {31'b0, intr},    {31'b0, (m_state == S_REQ)});
    check("userRun", {31'b0, userRun}, {31'b0, (m_state == S_USER)});
    check("intCode", intCode, m_code);
    check("intPc",   intPc,   m_pc);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    #1;
    check_all();
    check("rst_intr", {31'b0, intr}, 32'd0);
    #11 rst = 1'b1;

    // Timer: slice of QUANTUM user cycles, then a 1-cycle intr with inta tied to intr
    userMode = 1'b1; pc = 32'h40;
    step();
    userMode = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      check("tmr_early_intr", {31'b0, intr}, 32'd0);
    end
    step();
    check("tmr_intr", {31'b0, intr}, 32'd1);
    check("tmr_code", intCode, 32'd1);
    check("tmr_pc",   intPc,   32'h40);
    inta = intr;
    step();
    inta = intr;
    check("tmr_intr_drop", {31'b0, intr}, 32'd0);
    clearIntr = 1'b1;
    step();
    clearIntr = 1'b0;
    check("tmr_clr_code", intCode, 32'd0);
    check("tmr_clr_user", {31'b0, userRun}, 32'd0);

    // Priority: io and disk rise together
    userMode = 1'b1;
    step();
    userMode = 1'b0; ioReq = 1'b1; diskDone = 1'b1; pc = 32'h100;
    step();
    step();
    check("prio_first_code", intCode, 32'd2);
    check("prio_first_pc",   intPc,   32'h100);
    inta = 1'b1;
    step();
    inta = 1'b0; userMode = 1'b1;
    step();
    userMode = 1'b0;
    step();
    check("prio_second_intr", {31'b0, intr}, 32'd1);
    check("prio_second_code", intCode, 32'd3);
    inta = 1'b1;
    step();
    inta = 1'b0; clearIntr = 1'b1;
    step();
    clearIntr = 1'b0; ioReq = 1'b0; diskDone = 1'b0;
    step();

    // Kernel non-preemption: three io pulses collapse into one request
    for (int i = 0; i < 3; i++) begin
      ioReq = 1'b1; step();
      ioReq = 1'b0; step();
    end
    for (int i = 0; i < 20; i++) begin
      step();
      check("kern_no_intr", {31'b0, intr}, 32'd0);
    end
    userMode = 1'b1;
    step();
    userMode = 1'b0;
    step();
    check("kern_io_code", intCode, 32'd2);
    inta = 1'b1;
    step();
    inta = 1'b0; userMode = 1'b1;
    step();
    userMode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("kern_no_second", {31'b0, intr}, 32'd0);
    end
    kernelMode = 1'b1;
    step();
    kernelMode = 1'b0;

    // Syscall collides with a disk edge
    userMode = 1'b1;
    step();
    userMode = 1'b0;
    step(); step();
    kernelMode = 1'b1; diskDone = 1'b1;
    step();
    kernelMode = 1'b0;
    check("sys_user", {31'b0, userRun}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("sys_no_intr", {31'b0, intr}, 32'd0);
    end
    userMode = 1'b1;
    step();
    userMode = 1'b0;
    step();
    check("sys_disk_code", intCode, 32'd3);

    // Handshake: intr holds while inta stays low
    for (int i = 0; i < 5; i++) begin
      step();
      check("hs_intr_hold", {31'b0, intr}, 32'd1);
    end
    inta = 1'b1;
    step();
    inta = 1'b0; clearIntr = 1'b1;
    step();
    clearIntr = 1'b0; diskDone = 1'b0; inta = 1'b1;
    step();
    inta = 1'b0;
    check("ign_inta_user", {31'b0, userRun}, 32'd0);
    check("ign_inta_code", intCode, 32'd0);
    userMode = 1'b1;
    step();
    userMode = 1'b0; clearIntr = 1'b1;
    step();
    clearIntr = 1'b0;
    check("ign_clr_user", {31'b0, userRun}, 32'd1);
    check("ign_clr_code", intCode, 32'd0);

    // Async reset in SERVICE with a pending source that must be lost
    diskDone = 1'b1; pc = 32'h200;
    step();
    step();
    inta = 1'b1;
    step();
    inta = 1'b0; ioReq = 1'b1;
    step();
    check("rst_pre_code", intCode, 32'd3);
    check("rst_pre_pc",   intPc,   32'h200);
    ioReq = 1'b0; diskDone = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_intCode", intCode, 32'd0);
    check("arst_intPc",   intPc,   32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b1;
    step();
    userMode = 1'b1;
    step();
    userMode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("arst_no_intr", {31'b0, intr}, 32'd0);
    end
    ioReq = 1'b1;
    step();
    step();
    check("arst_new_code", intCode, 32'd2);
    ioReq = 1'b0; inta = 1'b1;
    step();
    inta = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      userMode   = ($urandom_range(0, 5) == 0);
      kernelMode = ($urandom_range(0, 11) == 0);
      inta       = ($urandom_range(0, 2) == 0);
      clearIntr  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) ioReq = !ioReq;
      if ($urandom_range(0, 7) == 0) diskDone = !diskDone;
      pc = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        #1 rst = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
